fetch_buffer: RTL

Receiving end of the instruction-fetch interface. It captures each fetched instruction and its PC into a small FIFO and presents them to decode with a valid/ready handshake. It also drives the PC-advance enable back to the fetch stage using credit-based backpressure that accounts for the one-cycle instruction-memory read. It squashes buffered and in-flight wrong-path instructions when a branch redirect occurs.

---
 rtl/fetch_buffer_if.sv | 31 +++
 rtl/fetch_buffer.sv | 87 ++++++++
 2 files changed

// File: rtl/fetch_buffer_if.sv
// Fetch-return and decode-side handshake bundle for fetch_buffer.
// Parameters must match the fetch_buffer instance that uses the slave modport.
interface fetch_buffer_if #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    localparam int LW = $clog2(DEPTH + 1);

    logic               fetch_valid;
    logic [PC_W-1:0]    fetch_pc;
    logic [INSTR_W-1:0] fetch_instr;
    logic               flush;
    logic               pc_ready;
    logic               dec_valid;
    logic               dec_ready;
    logic [PC_W-1:0]    dec_pc;
    logic [INSTR_W-1:0] dec_instr;
    logic [LW-1:0]      level;
    logic               overflow;

    modport master (
        output fetch_valid, fetch_pc, fetch_instr, flush, dec_ready,
        input  pc_ready, dec_valid, dec_pc, dec_instr, level, overflow
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_instr, flush, dec_ready,
        output pc_ready, dec_valid, dec_pc, dec_instr, level, overflow
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: show-ahead FIFO toward decode, credit-based PC advance
// that reserves a slot for the one outstanding memory read, and redirect squash.
module fetch_buffer #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input logic           clk,
    input logic           reset,
    fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW:0]   FULL_X = (CW + 1)'(DEPTH);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               inflight_q;
    logic               squash_q;
    logic               overflow_q;

    logic               push;
    logic               pop;
    logic               drop;
    logic               dec_valid;
    logic               pc_ready;
    logic               beat_live;
    logic [CW:0]        credits;

    // Pops are deliberately not credited: the PC only advances when the slot
    // is guaranteed even if decode stalls.
    always_comb begin
        credits   = {1'b0, count} + {{CW{1'b0}}, inflight_q};
        pc_ready  = !bus.flush && (credits < FULL_X);
        dec_valid = (count != '0) && !bus.flush;
        pop       = dec_valid && bus.dec_ready;
        beat_live = bus.fetch_valid && !bus.flush && !squash_q;
        push      = beat_live && ((count < FULL) || pop);
        drop      = beat_live && (count == FULL) && !pop;
    end

    assign bus.pc_ready  = pc_ready;
    assign bus.dec_valid = dec_valid;
    assign bus.dec_pc    = (count != '0) ? pc_mem[rd_ptr]    : '0;
    assign bus.dec_instr = (count != '0) ? instr_mem[rd_ptr] : '0;
    assign bus.level     = count;
    assign bus.overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= bus.fetch_pc;
            instr_mem[wr_ptr] <= bus.fetch_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            inflight_q <= pc_ready;
            squash_q   <= bus.flush;
            if (drop) overflow_q <= 1'b1;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule
